kmeans_acc_update_k2_d4: RTL and testbench
==========================================

# kmeans_acc_update_k2_d4

Consumer stage for the k=2, 4-dimension k-means datapath. It takes each classified point from the assignment pipeline: four dimension values plus the selected centroid index. It accumulates per-centroid, per-dimension sums and point counts over one pass. When the pass ends, a sequential divider computes the eight new centroid coordinates and presents them atomically to the top level's centroid registers with a one-cycle `done` pulse.

## Interface
- `input_data_width`, 8, width of each dimension value and each centroid coordinate (W).
- `input_data_qty_bit_width`, 8, log2 of the maximum number of points per pass (Q); maximum points per pass = 2^Q.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state immediately.
- `in_valid`  in  1  classified point present this cycle.
- `in_last`  in  1  qualifies `in_valid`: this point is the last one of the pass.
- `in_centroid`  in  1  selected centroid index (0 or 1).
- `in_d0`..`in_d3`  in  W each  point coordinates.
- `in_ready`  out  1  high only in ACC; reset value 1.
- `new_k0d0`..`new_k0d3`, `new_k1d0`..`new_k1d3`  out  W each  updated centroids; reset value 0.
- `empty_k0`, `empty_k1`  out  1  the last completed pass assigned zero points to that centroid; reset value 0.
- `done`  out  1  one-cycle pulse when the `new_*` outputs update; reset value 0.
- `overrun`  out  1  sticky error flag, cleared only by reset; reset value 0.

## Operation
- Accumulators:
  - 8 sums, width W+Q. At the defaults the maximum is 256·255 = 65280 in 16 bits, so sums cannot overflow.
  - 2 counts, width Q+1.
  - All are cleared by reset and on DONE→ACC.
- FSM has three states: ACC, DIV, DONE.
- ACC:
  - A beat is accepted when `in_valid`=1.
  - An accepted beat adds `in_d*` to the sums of centroid `in_centroid` and increments that centroid's count.
  - If the beat also has `in_last`=1, it is accumulated and the FSM goes to DIV.
  - If count0+count1 already equals 2^Q, the beat is dropped and `overrun` is set. A dropped beat carrying `in_last` still moves the FSM to DIV.
- DIV:
  - Computes 8 floor divisions sum/count in fixed order: k0d0..k0d3, then k1d0..k1d3.
  - Uses one restoring divider producing 1 quotient bit per cycle, W+Q cycles per division. Total is 8·(W+Q) cycles (128 at defaults).
  - The quotient's low W bits go into staging registers. Since mean ≤ max input, no truncation loss occurs.
  - Count = 0: the division still takes its full slot (fixed latency), the result is discarded, and the staging register for that coordinate keeps its current output value.
  - `in_valid`=1 in DIV or DONE: the beat is dropped, `overrun` is set, and accumulation is unaffected.
- DONE (1 cycle):
  - `done`=1.
  - All 8 `new_*` outputs and both `empty_*` flags update on the edge entering DONE.
  - Next edge: accumulators clear and the FSM returns to ACC.
- Reset asserted at any time: all outputs take their reset values asynchronously, the FSM goes to ACC, and any partial pass or division is discarded without a `done` pulse.

## Timing
- Accumulation has no latency constraint on the input side. Back-to-back beats are accepted every cycle in ACC.
- Let edge E0 be the edge that accepts the `in_last` beat:
  - DIV occupies edges E1..E128.
  - The edge entering DONE is E129, where `done` goes high and `new_*` update.
  - `done` falls at E130, where `in_ready` returns to 1.
- With default parameters the end-to-end update latency is therefore 129 edges. In general it is 8·(W+Q)+1.
- `new_*` are stable between `done` pulses. They never show partial results.
- Upstream has no backpressure. The top level must not present beats while `in_ready`=0; `overrun` records any violation.

## Test plan
- Reset: hold `rst`=0 with random inputs. Required: all `new_*`=0, `done`=0, `overrun`=0, `in_ready`=1. After release, `in_ready` stays 1.
- Basic pass:
  - Stimulus: c0 (10,20,30,40) and (13,21,30,41); c1 (200,100,50,0) and (201,101,51,1) with `in_last`.
  - Required: `done` exactly 129 edges after the last beat; k0=(11,20,30,40), k1=(200,100,50,0); `empty_*`=0.
- Empty cluster:
  - Stimulus: after the basic pass, a pass with 3 points all to c0: (3,3,3,3), (4,4,4,4), (5,5,5,5).
  - Required: k0=(4,4,4,4), k1 unchanged (200,100,50,0), `empty_k1`=1, `empty_k0`=0.
- Full-scale pass:
  - Stimulus: 256 points, all dimensions 255, all to c1, last flagged.
  - Required: k1=(255,255,255,255), `overrun`=0, `empty_k0`=1.
- Overrun:
  - Stimulus: pulse `in_valid` with (99,99,99,99) to c0 during DIV of the basic pass.
  - Required: `overrun`=1, results identical to the basic pass. A 257th beat in one pass is dropped and also sets `overrun`.
- Reset mid-DIV:
  - Stimulus: assert `rst` 50 edges after E0.
  - Required: outputs return to 0 immediately, no `done` pulse, `in_ready`=1 after release. A subsequent basic pass gives the same results as before.

Source files
------------

// File: rtl/kmeans_acc_update_k2_d4_if.sv
// kmeans_acc_update_k2_d4_if: classified-point input and centroid-update bundle
// between the assignment pipeline and the accumulate/update stage.
interface kmeans_acc_update_k2_d4_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_last;
   logic         in_centroid;
   logic [W-1:0] in_d0, in_d1, in_d2, in_d3;
   logic         in_ready;
   logic [W-1:0] new_k0d0, new_k0d1, new_k0d2, new_k0d3;
   logic [W-1:0] new_k1d0, new_k1d1, new_k1d2, new_k1d3;
   logic         empty_k0, empty_k1;
   logic         done;
   logic         overrun;

   modport master (
      output in_valid, in_last, in_centroid, in_d0, in_d1, in_d2, in_d3,
      input  in_ready, new_k0d0, new_k0d1, new_k0d2, new_k0d3,
             new_k1d0, new_k1d1, new_k1d2, new_k1d3,
             empty_k0, empty_k1, done, overrun
   );

   modport slave (
      input  in_valid, in_last, in_centroid, in_d0, in_d1, in_d2, in_d3,
      output in_ready, new_k0d0, new_k0d1, new_k0d2, new_k0d3,
             new_k1d0, new_k1d1, new_k1d2, new_k1d3,
             empty_k0, empty_k1, done, overrun
   );
endinterface

// File: rtl/kmeans_acc_update_k2_d4.sv
// kmeans_acc_update_k2_d4: accumulates per-centroid sums/counts over a pass, then
// computes the 8 new centroid means with one shared restoring divider.
module kmeans_acc_update_k2_d4 #(
   parameter int input_data_width         = 8,
   parameter int input_data_qty_bit_width = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   kmeans_acc_update_k2_d4_if.slave  bus_io
);
   localparam int W  = input_data_width;
   localparam int Q  = input_data_qty_bit_width;
   localparam int N  = W + Q;
   localparam int BW = $clog2(N);
   localparam logic [Q+1:0] CAP     = {1'b0, 1'b1, {Q{1'b0}}};
   localparam logic [Q:0]   CNT_ONE = {{Q{1'b0}}, 1'b1};

   typedef enum logic [1:0] {ACC, DIV, DONE} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   sum_q   [2][4], sum_d   [2][4];
   logic [Q:0]     cnt_q   [2],    cnt_d   [2];
   logic [W-1:0]   stage_q [2][4], stage_d [2][4];
   logic [W-1:0]   new_q   [2][4], new_d   [2][4];
   logic [1:0]     empty_q, empty_d;
   logic           ovr_q, ovr_d;
   logic [3:0]     idx_q, idx_d;
   logic [BW-1:0]  bit_q, bit_d;
   logic [N-1:0]   quo_q, quo_d;
   logic [Q:0]     rem_q, rem_d;

   logic [W-1:0]   din [4];
   logic           c;
   logic           full;
   logic [Q+1:0]   total;
   logic           first;
   logic [N-1:0]   src;
   logic [Q:0]     rem_in;
   logic [Q:0]     dvsr;
   logic [Q+1:0]   rs;
   logic           ge;
   logic [N-1:0]   q_next;

   assign din[0] = bus_io.in_d0;
   assign din[1] = bus_io.in_d1;
   assign din[2] = bus_io.in_d2;
   assign din[3] = bus_io.in_d3;
   assign c      = bus_io.in_centroid;
   assign total  = {1'b0, cnt_q[0]} + {1'b0, cnt_q[1]};
   assign full   = total == CAP;

   // One quotient bit per cycle; the first cycle of each slot loads the dividend directly.
   assign first  = bit_q == '0;
   assign src    = first ? sum_q[idx_q[2]][idx_q[1:0]] : quo_q;
   assign rem_in = first ? '0 : rem_q;
   assign dvsr   = cnt_q[idx_q[2]];
   assign rs     = {rem_in, src[N-1]};
   assign ge     = rs >= {1'b0, dvsr};
   assign q_next = {src[N-2:0], ge};

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      new_d   = new_q;
      empty_d = empty_q;
      ovr_d   = ovr_q;
      idx_d   = idx_q;
      bit_d   = bit_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      case (state_q)
         ACC: if (bus_io.in_valid) begin
            if (full) ovr_d = 1'b1;
            else begin
               for (int j = 0; j < 4; j++) sum_d[c][j] = sum_q[c][j] + N'(din[j]);
               cnt_d[c] = cnt_q[c] + CNT_ONE;
            end
            if (bus_io.in_last) begin
               state_d = DIV;
               idx_d   = '0;
               bit_d   = '0;
            end
         end
         DIV: begin
            ovr_d = ovr_q | bus_io.in_valid;
            if (idx_q[3]) begin
               state_d = DONE;
               new_d   = stage_q;
               empty_d = {cnt_q[1] == '0, cnt_q[0] == '0};
            end else begin
               quo_d = q_next;
               rem_d = ge ? rs[Q:0] - dvsr : rs[Q:0];
               if (bit_q == BW'(N - 1)) begin
                  // An empty centroid keeps its previous coordinate.
                  stage_d[idx_q[2]][idx_q[1:0]] = (dvsr == '0) ? new_q[idx_q[2]][idx_q[1:0]] : q_next[W-1:0];
                  bit_d = '0;
                  idx_d = idx_q + 4'd1;
               end else bit_d = bit_q + BW'(1);
            end
         end
         default: begin
            ovr_d   = ovr_q | bus_io.in_valid;
            state_d = ACC;
            sum_d   = '{default: '0};
            cnt_d   = '{default: '0};
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACC;
         sum_q   <= '{default: '0};
         cnt_q   <= '{default: '0};
         stage_q <= '{default: '0};
         new_q   <= '{default: '0};
         empty_q <= '0;
         ovr_q   <= 1'b0;
         idx_q   <= '0;
         bit_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         new_q   <= new_d;
         empty_q <= empty_d;
         ovr_q   <= ovr_d;
         idx_q   <= idx_d;
         bit_q   <= bit_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
      end
   end

   assign bus_io.in_ready = state_q == ACC;
   assign bus_io.done     = state_q == DONE;
   assign bus_io.overrun  = ovr_q;
   assign bus_io.empty_k0 = empty_q[0];
   assign bus_io.empty_k1 = empty_q[1];
   assign bus_io.new_k0d0 = new_q[0][0];
   assign bus_io.new_k0d1 = new_q[0][1];
   assign bus_io.new_k0d2 = new_q[0][2];
   assign bus_io.new_k0d3 = new_q[0][3];
   assign bus_io.new_k1d0 = new_q[1][0];
   assign bus_io.new_k1d1 = new_q[1][1];
   assign bus_io.new_k1d2 = new_q[1][2];
   assign bus_io.new_k1d3 = new_q[1][3];
endmodule

// File: tb/tb_kmeans_acc_update_k2_d4.sv
// tb_kmeans_acc_update_k2_d4: directed passes checked every cycle against a
// pass-level model, plus literal expectations for each scenario.
module tb_kmeans_acc_update_k2_d4;
   localparam int W = 8;
   localparam int Q = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   kmeans_acc_update_k2_d4_if #(.W(W)) bus ();

   kmeans_acc_update_k2_d4 #(
      .input_data_width(W),
      .input_data_qty_bit_width(Q)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus_io(bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Pass-level model: sums and counts per centroid, results scheduled 129 edges after the last beat.
   int m_e = 0, m_e0 = 0;
   bit m_busy = 0, m_ovr = 0, m_ready = 1, m_done = 0;
   int ms [2][4], mn [2], m_new [2][4], p_new [2][4];
   bit m_empty [2], p_empty [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         mn[k] = 0; m_empty[k] = 0; p_empty[k] = 0;
         for (int d = 0; d < 4; d++) begin ms[k][d] = 0; m_new[k][d] = 0; p_new[k][d] = 0; end
      end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy = 0; m_ovr = 0; m_ready = 1; m_done = 0;
            for (int k = 0; k < 2; k++) begin
               mn[k] = 0; m_empty[k] = 0;
               for (int d = 0; d < 4; d++) begin ms[k][d] = 0; m_new[k][d] = 0; end
            end
         end else begin
            m_e++;
            m_done = 0;
            if (m_busy && m_e == m_e0 + 129) begin
               m_new = p_new; m_empty = p_empty; m_done = 1;
            end
            if (bus.in_valid === 1'b1) begin
               int c;
               int vals [4];
               c = int'(bus.in_centroid);
               vals[0] = int'(bus.in_d0); vals[1] = int'(bus.in_d1);
               vals[2] = int'(bus.in_d2); vals[3] = int'(bus.in_d3);
               if (m_busy || mn[0] + mn[1] == 256) m_ovr = 1;
               else begin
                  for (int d = 0; d < 4; d++) ms[c][d] += vals[d];
                  mn[c]++;
               end
               if (!m_busy && bus.in_last === 1'b1) begin
                  for (int k = 0; k < 2; k++) begin
                     p_empty[k] = mn[k] == 0;
                     for (int d = 0; d < 4; d++) p_new[k][d] = mn[k] != 0 ? ms[k][d] / mn[k] : m_new[k][d];
                     mn[k] = 0;
                     for (int d = 0; d < 4; d++) ms[k][d] = 0;
                  end
                  m_busy = 1; m_e0 = m_e;
               end
            end
            if (m_busy && m_e == m_e0 + 130) m_busy = 0;
            m_ready = !m_busy;
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("in_ready", bus.in_ready, m_ready);
         chk("done", bus.done, m_done);
         chk("overrun", bus.overrun, m_ovr);
         chk("empty_k0", bus.empty_k0, m_empty[0]);
         chk("empty_k1", bus.empty_k1, m_empty[1]);
         chk("new_k0d0", bus.new_k0d0, m_new[0][0]);
         chk("new_k0d1", bus.new_k0d1, m_new[0][1]);
         chk("new_k0d2", bus.new_k0d2, m_new[0][2]);
         chk("new_k0d3", bus.new_k0d3, m_new[0][3]);
         chk("new_k1d0", bus.new_k1d0, m_new[1][0]);
         chk("new_k1d1", bus.new_k1d1, m_new[1][1]);
         chk("new_k1d2", bus.new_k1d2, m_new[1][2]);
         chk("new_k1d3", bus.new_k1d3, m_new[1][3]);
      end
   end

   task automatic send(input bit c, input int a, input int b, input int x, input int y, input bit last);
      bus.in_valid = 1'b1; bus.in_centroid = c; bus.in_last = last;
      bus.in_d0 = 8'(a); bus.in_d1 = 8'(b); bus.in_d2 = 8'(x); bus.in_d3 = 8'(y);
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
   endtask

   // Counts edges after the last beat until done; optionally pokes a beat during DIV.
   task automatic wait_done(input int inj, output int n);
      n = 0;
      for (int i = 1; i <= 200 && n == 0; i++) begin
         @(posedge clk); #1;
         bus.in_valid = (i == inj);
         if (i == inj) begin
            bus.in_centroid = 1'b0;
            bus.in_d0 = 8'd99; bus.in_d1 = 8'd99; bus.in_d2 = 8'd99; bus.in_d3 = 8'd99;
         end
         if (bus.done === 1'b1) n = i;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic check_k(input string nm, input int k0 [4], input int k1 [4]);
      chk({nm, "_k0d0"}, bus.new_k0d0, k0[0]);
      chk({nm, "_k0d1"}, bus.new_k0d1, k0[1]);
      chk({nm, "_k0d2"}, bus.new_k0d2, k0[2]);
      chk({nm, "_k0d3"}, bus.new_k0d3, k0[3]);
      chk({nm, "_k1d0"}, bus.new_k1d0, k1[0]);
      chk({nm, "_k1d1"}, bus.new_k1d1, k1[1]);
      chk({nm, "_k1d2"}, bus.new_k1d2, k1[2]);
      chk({nm, "_k1d3"}, bus.new_k1d3, k1[3]);
   endtask

   task automatic basic_beats();
      send(1'b0, 10, 20, 30, 40, 1'b0);
      send(1'b0, 13, 21, 30, 41, 1'b0);
      send(1'b1, 200, 100, 50, 0, 1'b0);
      send(1'b1, 201, 101, 51, 1, 1'b1);
   endtask

   task automatic finish_pass(input string nm, input int inj);
      int n;
      wait_done(inj, n);
      chk({nm, "_latency"}, n, 129);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_centroid = 1'b0;
      bus.in_d0 = '0; bus.in_d1 = '0; bus.in_d2 = '0; bus.in_d3 = '0;
      repeat (6) begin
         @(posedge clk); #1;
         bus.in_valid = 1'($urandom); bus.in_last = 1'($urandom); bus.in_centroid = 1'($urandom);
         bus.in_d0 = 8'($urandom); bus.in_d1 = 8'($urandom); bus.in_d2 = 8'($urandom); bus.in_d3 = 8'($urandom);
      end
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_done", bus.done, 0);
      chk("rst_overrun", bus.overrun, 0);
      check_k("rst", '{0, 0, 0, 0}, '{0, 0, 0, 0});
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("post_rst_ready", bus.in_ready, 1);

      basic_beats();
      finish_pass("basic", 0);
      check_k("basic", '{11, 20, 30, 40}, '{200, 100, 50, 0});
      chk("basic_empty_k0", bus.empty_k0, 0);
      chk("basic_empty_k1", bus.empty_k1, 0);
      chk("basic_overrun", bus.overrun, 0);
      @(posedge clk); #1;
      chk("basic_ready_back", bus.in_ready, 1);
      chk("basic_done_fell", bus.done, 0);

      send(1'b0, 3, 3, 3, 3, 1'b0);
      send(1'b0, 4, 4, 4, 4, 1'b0);
      send(1'b0, 5, 5, 5, 5, 1'b1);
      finish_pass("empty", 0);
      check_k("empty", '{4, 4, 4, 4}, '{200, 100, 50, 0});
      chk("empty_empty_k0", bus.empty_k0, 0);
      chk("empty_empty_k1", bus.empty_k1, 1);
      @(posedge clk); #1;

      for (int i = 0; i < 256; i++) send(1'b1, 255, 255, 255, 255, i == 255);
      finish_pass("full", 0);
      check_k("full", '{4, 4, 4, 4}, '{255, 255, 255, 255});
      chk("full_overrun", bus.overrun, 0);
      chk("full_empty_k0", bus.empty_k0, 1);
      chk("full_empty_k1", bus.empty_k1, 0);
      @(posedge clk); #1;

      basic_beats();
      finish_pass("ovr_div", 10);
      check_k("ovr_div", '{11, 20, 30, 40}, '{200, 100, 50, 0});
      chk("ovr_div_overrun", bus.overrun, 1);
      @(posedge clk); #1;

      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) send(1'b1, 10, 10, 10, 10, 1'b0);
      chk("cap_overrun_before", bus.overrun, 0);
      send(1'b0, 200, 200, 200, 200, 1'b1);
      chk("cap_overrun", bus.overrun, 1);
      finish_pass("cap", 0);
      check_k("cap", '{0, 0, 0, 0}, '{10, 10, 10, 10});
      chk("cap_empty_k0", bus.empty_k0, 1);
      @(posedge clk); #1;

      basic_beats();
      repeat (50) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("middiv_ready", bus.in_ready, 1);
      chk("middiv_done", bus.done, 0);
      chk("middiv_overrun", bus.overrun, 0);
      check_k("middiv", '{0, 0, 0, 0}, '{0, 0, 0, 0});
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("middiv_ready_after", bus.in_ready, 1);
      basic_beats();
      finish_pass("rerun", 0);
      check_k("rerun", '{11, 20, 30, 40}, '{200, 100, 50, 0});
      chk("rerun_empty_k1", bus.empty_k1, 0);
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
